// File: rtl/timer_pkg.sv
// Shared types for the programmable timer.
// Channel state encoding and mode constants.
package timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: final/mode registers, count and IDLE/RUN state.
// Expiry compares against the configuration held before the current edge.
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_final,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [WIDTH-1:0] final_q;
    logic             mode;

    assign busy = (state == RUN);

    // Configuration, state, count and expiry pulse; stop beats start and expiry.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            count   <= '0;
            done    <= 1'b0;
            final_q <= '1;
            mode    <= MODE_PERIODIC;
        end else begin
            done <= 1'b0;
            if (cfg_we) begin
                final_q <= cfg_final;
                mode    <= cfg_oneshot;
            end
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state <= RUN;
                        count <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (start) begin
                        count <= '0;
                    end else if (tick) begin
                        if (count >= final_q) begin
                            count <= '0;
                            done  <= 1'b1;
                            if (mode == MODE_ONESHOT) begin
                                state <= IDLE;
                            end
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/prog_timer.sv
// Multi-channel programmable timer with a shared prescaler tick.
// Config writes are decoded here and steered to one channel.
module prog_timer
    import timer_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    parameter  int PRESCALE = 1,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cfg_we,
    input  logic [CW-1:0]             cfg_ch,
    input  logic [WIDTH-1:0]          cfg_final,
    input  logic                      cfg_oneshot,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       done
);

    logic [PW-1:0]       pre;
    logic                tick;
    logic [CHANNELS-1:0] ch_we;

    assign tick = (pre == PW'(PRESCALE - 1));

    // Free-running prescaler, wraps at PRESCALE-1; never resynchronised by start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Write-enable decode; out-of-range channel indices select nothing.
    always_comb begin
        ch_we = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ch_we[i] = cfg_we && (int'(cfg_ch) == i);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        timer_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .tick       (tick),
            .cfg_we     (ch_we[i]),
            .cfg_final  (cfg_final),
            .cfg_oneshot(cfg_oneshot),
            .start      (start[i]),
            .stop       (stop[i]),
            .count      (count[i*WIDTH +: WIDTH]),
            .busy       (busy[i]),
            .done       (done[i])
        );
    end

endmodule

// File: doc/prog_timer.md
PROG_TIMER -- requirements
Module: prog_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning counter/final-value width per channel (>=2).
REQ-002 SHALL have parameter CHANNELS, default 4, meaning number of independent timer channels (>=1).
REQ-003 SHALL have parameter PRESCALE, default 1, meaning clock cycles per count tick (>=1), shared by all channels.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous active-low reset; one clock, reset sampled on rising edge of clk.
REQ-006 SHALL have port cfg_we  input  1  configuration write strobe.
REQ-007 SHALL have port cfg_ch  input  max(1,$clog2(CHANNELS))  channel index for cfg_we.
REQ-008 SHALL have port cfg_final  input  WIDTH  final value written to the selected channel.
REQ-009 SHALL have port cfg_oneshot  input  1  mode written to the selected channel: 0 periodic, 1 one-shot.
REQ-010 SHALL have port start  input  CHANNELS  per-channel start/restart request.
REQ-011 SHALL have port stop  input  CHANNELS  per-channel stop request.
REQ-012 SHALL have port count  output  CHANNELS*WIDTH  current count, channel i at bits [i*WIDTH +: WIDTH].
REQ-013 SHALL have port busy  output  CHANNELS  channel i is in RUN.
REQ-014 SHALL have port done  output  CHANNELS  one-cycle expiry pulse per channel.

Function
REQ-015 SHALL generate a shared tick: prescaler counts 0..PRESCALE-1 continuously from reset; tick high in the cycle prescaler = PRESCALE-1; PRESCALE=1 gives tick every cycle.
REQ-016 SHALL hold per channel a final register and mode register; cfg_we writes both for channel cfg_ch on the edge; cfg_ch >= CHANNELS ignored.
REQ-017 SHALL implement per-channel states IDLE and RUN; busy = (state == RUN).
REQ-018 IDLE -> RUN on start[i]: count cleared to 0 on that edge; prescaler not resynchronised.
REQ-019 RUN with start[i]: restart, count cleared to 0, stays RUN.
REQ-020 RUN with stop[i]: -> IDLE, count holds its value, no done pulse; stop wins over simultaneous start and simultaneous expiry.
REQ-021 RUN on tick with count < final: count increments by 1.
REQ-022 RUN on tick with count >= final: count <= 0, done[i] <= 1 for exactly one cycle; periodic stays RUN, one-shot -> IDLE.
REQ-023 Period in periodic mode SHALL be (final+1) ticks; final = 0 gives done every tick.
REQ-024 A cfg_we to a running channel SHALL take effect for all comparisons after the write edge; if new final < count, expiry occurs on the next tick (>= rule, no wrap through 2^WIDTH).
REQ-025 cfg_we and start to the same channel on the same edge SHALL start with the newly written configuration.
REQ-026 No tick in IDLE SHALL change count; start in IDLE with stop same cycle leaves channel IDLE, count unchanged.
REQ-027 done SHALL be registered; all outputs registered, no combinational path from inputs to outputs.
REQ-028 Channels SHALL be fully independent apart from the shared tick.

Reset
REQ-029 While reset_n = 0 at a rising edge: all channels IDLE, count = 0, done = 0, busy = 0, final registers = all ones, mode = periodic, prescaler = 0.
REQ-030 Reset mid-operation SHALL override start, stop and cfg_we in the same cycle; no done pulse is produced by reset.

Structure
REQ-031 Shared package timer_pkg SHALL hold the channel state enum (IDLE, RUN) and mode constants (MODE_PERIODIC, MODE_ONESHOT).
REQ-032 Per-channel logic SHALL be sub-module timer_channel (WIDTH parameter), instantiated CHANNELS times by a generate loop; prescaler and config decode live in prog_timer.

Verification
REQ-033 PRESCALE=1, ch0 final=3 periodic, start -> count 0,1,2,3,0,1..., done[0] high in each cycle count returns to 0 (every 4 cycles), busy stays 1.
REQ-034 ch1 final=2 one-shot, start -> count 0,1,2,0, single done pulse, busy falls with done, no further counting.
REQ-035 PRESCALE=4, ch0 final=1 periodic -> count changes every 4 cycles, done every 8 cycles.
REQ-036 ch0 running at count=5, cfg_we final=2 -> next tick count=0 with done; start+stop same cycle -> IDLE, count held, no done.
REQ-037 reset_n low for one cycle while two channels run -> next cycle all count=0, busy=0, done=0; final=255 readback by starting and observing 256-tick period.
REQ-038 Randomised start/stop/cfg_we across all channels checked against a reference model per REQ-015..028.
